clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 101 ++++++++++
 tb/tb_clk_div_prog.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider with per-channel shadowed configuration.
// Each channel emits a wrap tick every div+1 cycles and a square or pulse fdiv.
module clk_div_prog #(
  parameter int          CHANNELS    = 2,
  parameter int          WIDTH       = 26,
  parameter int unsigned DEFAULT_DIV = 25000000,
  parameter int          CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  output logic [CHANNELS-1:0] fdiv,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] sdiv_reg;
    logic             mode_reg;
    logic             smode_reg;
    logic             pend_reg;
    logic             fdiv_reg;
    logic             tick_reg;

    logic             wr;
    logic             wrap;
    logic             hold;
    logic             apply;
    logic [WIDTH-1:0] div_next;
    logic             mode_next;

    // Out-of-range cfg_ch values never match any channel index, so they are dropped.
    assign wr        = cfg_we && (cfg_ch == CW'(gi));
    assign wrap      = (cnt_reg == div_reg);
    assign hold      = sync || !ch_en[gi];
    // Only a shadow that was already pending before this edge may be applied.
    assign apply     = pend_reg && (hold || wrap);
    assign div_next  = apply ? sdiv_reg : div_reg;
    assign mode_next = apply ? smode_reg : mode_reg;

    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt_reg   <= '0;
        div_reg   <= RST_DIV;
        mode_reg  <= 1'b0;
        sdiv_reg  <= RST_DIV;
        smode_reg <= 1'b0;
        pend_reg  <= 1'b0;
        fdiv_reg  <= 1'b0;
        tick_reg  <= 1'b0;
      end else begin
        div_reg  <= div_next;
        mode_reg <= mode_next;

        if (hold) begin
          cnt_reg  <= '0;
          fdiv_reg <= 1'b0;
          tick_reg <= 1'b0;
        end else if (wrap) begin
          cnt_reg  <= '0;
          tick_reg <= 1'b1;
          // A mode switch restarts fdiv low so the new waveform starts clean.
          if (mode_next != mode_reg)
            fdiv_reg <= 1'b0;
          else if (mode_reg)
            fdiv_reg <= 1'b1;
          else
            fdiv_reg <= !fdiv_reg;
        end else begin
          cnt_reg  <= cnt_reg + WIDTH'(1);
          tick_reg <= 1'b0;
          if (mode_reg)
            fdiv_reg <= 1'b0;
        end

        // A write landing on an apply edge wins, leaving the new shadow pending.
        if (wr) begin
          sdiv_reg  <= cfg_div;
          smode_reg <= cfg_mode;
          pend_reg  <= 1'b1;
        end else if (apply) begin
          pend_reg  <= 1'b0;
        end
      end
    end

    assign fdiv[gi]    = fdiv_reg;
    assign tick[gi]    = tick_reg;
    assign pending[gi] = pend_reg;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed vector bench for clk_div_prog (2 channels, 8-bit, default div 3), plus a
// 3-channel instance exercising out-of-range configuration writes.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ch_en;
  logic       sync;
  logic       cfg_we;
  logic       cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_mode;
  logic [1:0] fdiv;
  logic [1:0] tick;
  logic [1:0] pending;

  logic [2:0] ch_en3;
  logic       cfg_we3;
  logic [1:0] cfg_ch3;
  logic [7:0] cfg_div3;
  logic [2:0] fdiv3;
  logic [2:0] tick3;
  logic [2:0] pending3;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  clk_div_prog #(.CHANNELS(2), .WIDTH(8), .DEFAULT_DIV(3)) u_dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .fdiv(fdiv), .tick(tick), .pending(pending)
  );

  clk_div_prog #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(3)) u_dut3 (
    .clk(clk), .reset(reset), .ch_en(ch_en3), .sync(1'b0),
    .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_div(cfg_div3), .cfg_mode(1'b0),
    .fdiv(fdiv3), .tick(tick3), .pending(pending3)
  );

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic       sy;
    logic       we;
    logic       ch;
    logic [7:0] dv;
    logic       md;
    logic [1:0] ef;
    logic [1:0] et;
    logic [1:0] ep;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic rst, logic [1:0] en, logic sy, logic we,
                              logic ch, logic [7:0] dv, logic md,
                              logic [1:0] ef, logic [1:0] et, logic [1:0] ep);
    vec_t v;
    v.rst = rst; v.en = en; v.sy = sy; v.we = we; v.ch = ch;
    v.dv = dv; v.md = md; v.ef = ef; v.et = et; v.ep = ep;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check3(string name, logic [2:0] want);
    nvec++;
    if (pending3 !== want) begin
      nerr++;
      $display("FAIL %s: pending3=%b, want %b", name, pending3, want);
    end else begin
      $display("%s: pending3=%b", name, pending3);
    end
  endtask

  initial begin
    //   n rst en    sy we ch div   md  fdiv   tick   pending
    add(1, 0, 2'b11, 1, 1, 1, 8'd9, 1, 2'b00, 2'b00, 2'b00); // reset beats sync/cfg/en
    add(1, 0, 2'b00, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    // free run, div=3: tick at edges 4, 8
    add(3, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b01, 2'b00);
    add(3, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b01, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    // write div=1 at counter=1, applied on next wrap, then period 2
    add(1, 1, 2'b01, 0, 1, 0, 8'd1, 0, 2'b00, 2'b00, 2'b01);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b01);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b01, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b01, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b01, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b00, 2'b00);
    // write coincident with a wrap: applies one wrap later (div=2)
    add(1, 1, 2'b01, 0, 1, 0, 8'd2, 0, 2'b00, 2'b01, 2'b01);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b01);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b01, 2'b00);
    add(2, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b01, 2'b00);
    // write coincident with an apply: div=3 applied, div=1/pulse stays pending
    add(1, 1, 2'b01, 0, 1, 0, 8'd3, 0, 2'b00, 2'b00, 2'b01);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b01);
    add(1, 1, 2'b01, 0, 1, 0, 8'd1, 1, 2'b01, 2'b01, 2'b01);
    add(3, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b00, 2'b01);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b01, 2'b00); // mode change clears fdiv
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b01, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b01, 2'b00);
    // pending div=5, sync on a would-be wrap: applies, then period 6
    add(1, 1, 2'b01, 0, 1, 0, 8'd5, 0, 2'b00, 2'b00, 2'b01);
    add(1, 1, 2'b01, 1, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    add(5, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b01, 2'b00);
    add(5, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b01, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    // disable applies pending div=2, re-enable restarts from 0
    add(1, 1, 2'b01, 0, 1, 0, 8'd2, 0, 2'b00, 2'b00, 2'b01);
    add(1, 1, 2'b00, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    add(2, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b01, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b00, 2'b00);
    // channel 1: div=0 pulse mode -> tick and fdiv high every cycle
    add(1, 1, 2'b10, 0, 1, 1, 8'd0, 1, 2'b00, 2'b00, 2'b10);
    add(2, 1, 2'b10, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b10);
    add(1, 1, 2'b10, 0, 0, 0, 8'd0, 0, 2'b00, 2'b10, 2'b00);
    add(3, 1, 2'b10, 0, 0, 0, 8'd0, 0, 2'b10, 2'b10, 2'b00);
    // reset mid-count with a pending shadow: discarded, period back to 4
    add(1, 1, 2'b11, 0, 1, 0, 8'd7, 0, 2'b10, 2'b10, 2'b01);
    add(1, 0, 2'b11, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    add(3, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b01, 2'b00);
    add(1, 1, 2'b01, 0, 0, 0, 8'd0, 0, 2'b01, 2'b00, 2'b00);

    ch_en3 = 3'b000; cfg_we3 = 1'b0; cfg_ch3 = 2'd0; cfg_div3 = 8'd0;

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; ch_en = vecs[i].en; sync = vecs[i].sy; cfg_we = vecs[i].we;
      cfg_ch = vecs[i].ch; cfg_div = vecs[i].dv; cfg_mode = vecs[i].md;
      @(posedge clk); #1;
      nvec++;
      if (fdiv !== vecs[i].ef || tick !== vecs[i].et || pending !== vecs[i].ep) begin
        nerr++;
        $display("FAIL vec%0d: fdiv=%b tick=%b pending=%b, want fdiv=%b tick=%b pending=%b",
                 i, fdiv, tick, pending, vecs[i].ef, vecs[i].et, vecs[i].ep);
      end else begin
        $display("vec%0d: fdiv=%b tick=%b pending=%b", i, fdiv, tick, pending);
      end
    end
    cfg_we = 1'b0; sync = 1'b0;

    // Out-of-range channel on the 3-channel instance is ignored; in-range sets pending.
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd4;
    @(posedge clk); #1;
    check3("oor_write_ch3", 3'b000);
    cfg_ch3 = 2'd2;
    @(posedge clk); #1;
    check3("write_ch2", 3'b100);
    cfg_we3 = 1'b0;
    @(posedge clk); #1;
    check3("disabled_apply_ch2", 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
